jesd_link_ctrl: RTL and testbench
=================================

# jesd_link_ctrl

JESD204B receive link controller that sequences link bring-up across all lanes. Drives the SYNC~ request to the transmitter and holds or re-arms the per-lane CGS detectors. Waits for every enabled lane to report CGS lock, then for ILAS completion, and monitors character errors in DATA to force a resynchronisation. Sits above the per-lane CGS/ILAS/alignment blocks in the RX top level.

## Interface
- `NUM_LANES`, 4: number of lanes.
- `SYNC_HOLD_MIN`, 16: minimum cycles (beyond the first) SYNC~ is held low per request.
- `ILAS_TIMEOUT`, 1024: cycles allowed in ILAS before resync.
- `ERR_WINDOW`, 256: error-monitor window length in cycles.
- `ERR_THRESH`, 8: error beats within one window that force resync.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `link_en_i` in 1: link enable.
- `lane_en_i` in NUM_LANES: enabled-lane mask; stable while `link_en_i`=1.
- `cgs_detected_i` in NUM_LANES: per-lane CGS lock.
- `ilas_done_i` in NUM_LANES: per-lane ILAS complete (level).
- `lane_err_i` in NUM_LANES: per-lane character error this beat.
- `resync_req_i` in 1: software resync request (level, sampled).
- `sync_n_o` out 1: SYNC~ to transmitter, active-low.
- `lane_rst_o` out NUM_LANES: active-high reset to per-lane detectors; inverted at each instance.
- `link_up_o` out 1: link in DATA.
- `state_o` out 2: current state encoding.
- `resync_cnt_o` out 8: resync event count, saturating.

## Operation
- **States:** IDLE=0, SYNC=1, ILAS=2, DATA=3. Lanes with `lane_en_i`=0 are ignored in all checks.
- **Global priority:** `link_en_i`=0 or `lane_en_i`=0 forces IDLE on the next edge from any state.
- **IDLE:**
  - `sync_n_o`=1, `lane_rst_o`=all 1, `link_up_o`=0.
  - Goes to SYNC when `link_en_i`=1 and `lane_en_i`≠0.
- **SYNC:**
  - `sync_n_o`=0; `lane_rst_o`=~`lane_en_i`.
  - `hold_cnt` clears on entry and increments each cycle, saturating at SYNC_HOLD_MIN.
  - Goes to ILAS when `hold_cnt`==SYNC_HOLD_MIN and every enabled lane has `cgs_detected_i`=1.
- **ILAS:**
  - `sync_n_o`=1; `ilas_tmr` clears on entry and increments each cycle.
  - Goes to DATA when every enabled lane has `ilas_done_i`=1.
  - Otherwise returns to SYNC on any enabled lane losing `cgs_detected_i`, or on `ilas_tmr`==ILAS_TIMEOUT-1.
- **DATA:**
  - `link_up_o`=1, `sync_n_o`=1.
  - `err_cnt` (saturating at ERR_THRESH) increments on each beat where any enabled lane has `lane_err_i`=1.
  - `win_cnt` counts 0..ERR_WINDOW-1 and wraps. On wrap, `err_cnt` clears; an error in the wrap beat counts as 1 for the new window.
  - Returns to SYNC when `err_cnt` reaches ERR_THRESH, any enabled lane drops `cgs_detected_i`, or `resync_req_i`=1.
  - Both counters clear on entry.
- **Resync entry (SYNC from ILAS or DATA):**
  - `lane_rst_o` asserts on all enabled lanes for exactly the first SYNC cycle, then follows the SYNC rule.
  - `resync_cnt_o` increments, saturating at 255.
  - Entry from IDLE is not a resync.
- **Simultaneous events:** disable beats every other condition. In ILAS, `ilas_done` plus a CGS loss in the same beat goes to SYNC. In DATA, any combination of resync causes counts as one event.

## Timing
- **Reset values:**
  - `sync_n_o`=1, `lane_rst_o`=all 1, `link_up_o`=0, `state_o`=0, `resync_cnt_o`=0.
  - All counters 0.
- **Output timing:** all outputs are registered from the next-state decode, so they change on the same edge as `state_o`, with zero extra latency.
- **Input timing:** inputs are sampled on the rising edge; a condition true in cycle N moves the state at the N→N+1 edge.
- **SYNC~ low time:** at least SYNC_HOLD_MIN+1 cycles per request.
- **ILAS timeout:** exits ILAS after exactly ILAS_TIMEOUT cycles if not done.
- **Counter widths:** `$clog2(X+1)` of each bound.
- **Mid-operation reset:** `rst_i` asserted mid-operation returns all outputs to reset values immediately (asynchronously).

## Structure
- Package `jesd_rx_pkg`:
  - `link_state_e` enum (2-bit, encodings above).
  - Shared JESD constants.
- Sub-module `jesd_err_monitor`: windowed saturating error counter. It takes `clear`, `beat_err` and `ERR_WINDOW`/`ERR_THRESH`, and outputs `thresh_hit`.
- The FSM, hold/ILAS timers and resync counter stay in `jesd_link_ctrl`.

## Test plan
- **Bring-up:** `lane_en_i`=4'hF with CGS on all lanes from cycle 3 → `sync_n_o` low 17 cycles, then ILAS. `ilas_done_i`=all 1 → DATA, `link_up_o`=1, `resync_cnt_o`=0.
- **Masked lane:** `lane_en_i`=4'h7 and lane 3 never locks → DATA is still reached; `lane_rst_o`[3]=1 throughout.
- **ILAS timeout:** `ilas_done_i` stuck 0 → SYNC exactly 1024 cycles after ILAS entry; one-cycle `lane_rst_o`=4'hF pulse; `resync_cnt_o`=1.
- **Error window:** 7 error beats in a window, then the wrap → stays in DATA. 8 error beats in one window → SYNC on the next edge.
- **Priority:** `resync_req_i` and `link_en_i`=0 in the same DATA cycle → IDLE, `resync_cnt_o` unchanged. `rst_i` pulsed mid-ILAS → outputs at reset values before the next clock edge.
- **Saturation:** 300 forced resyncs → `resync_cnt_o`=255.

Source files
------------

// File: rtl/jesd_rx_pkg.sv
// rtl/jesd_rx_pkg.sv - shared JESD204B RX link state encoding and default constants
package jesd_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_ILAS = 2'd2,
      ST_DATA = 2'd3
   } link_state_e;

   localparam int JESD_NUM_LANES     = 4;
   localparam int JESD_SYNC_HOLD_MIN = 16;
   localparam int JESD_ILAS_TIMEOUT  = 1024;
   localparam int JESD_ERR_WINDOW    = 256;
   localparam int JESD_ERR_THRESH    = 8;
   localparam int RESYNC_CNT_W       = 8;

endpackage

// File: rtl/jesd_err_monitor.sv
// rtl/jesd_err_monitor.sv - windowed saturating character-error counter
// thresh_hit is combinational on the count this beat would reach, so the FSM reacts on the same edge.
module jesd_err_monitor #(
   parameter int ERR_WINDOW = 256,
   parameter int ERR_THRESH = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic beat_err,
   output logic thresh_hit
);
   localparam int WIN_W = $clog2(ERR_WINDOW + 1);
   localparam int ERR_W = $clog2(ERR_THRESH + 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ERR_WINDOW - 1);
   localparam logic [ERR_W-1:0] THRESH   = ERR_W'(ERR_THRESH);

   logic [WIN_W-1:0] r_win_cnt;
   logic [ERR_W-1:0] r_err_cnt;
   logic             w_wrap;
   logic [ERR_W-1:0] w_err_nxt;

   assign w_wrap = (r_win_cnt == WIN_LAST);

   // An error on the wrap beat is the first error of the new window.
   always_comb begin
      w_err_nxt = r_err_cnt;
      if (w_wrap) begin
         w_err_nxt = beat_err ? ERR_W'(1) : '0;
      end else if (beat_err && (r_err_cnt != THRESH)) begin
         w_err_nxt = r_err_cnt + ERR_W'(1);
      end
   end

   assign thresh_hit = !clear && (w_err_nxt == THRESH);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_win_cnt <= '0;
         r_err_cnt <= '0;
      end else if (clear) begin
         r_win_cnt <= '0;
         r_err_cnt <= '0;
      end else begin
         r_win_cnt <= w_wrap ? '0 : r_win_cnt + WIN_W'(1);
         r_err_cnt <= w_err_nxt;
      end
   end

endmodule

// File: rtl/jesd_link_ctrl.sv
// rtl/jesd_link_ctrl.sv - JESD204B RX link bring-up and resync controller
// All outputs are registered from the next-state decode so they move on the same edge as state_o.
module jesd_link_ctrl
   import jesd_rx_pkg::*;
#(
   parameter int NUM_LANES     = JESD_NUM_LANES,
   parameter int SYNC_HOLD_MIN = JESD_SYNC_HOLD_MIN,
   parameter int ILAS_TIMEOUT  = JESD_ILAS_TIMEOUT,
   parameter int ERR_WINDOW    = JESD_ERR_WINDOW,
   parameter int ERR_THRESH    = JESD_ERR_THRESH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    link_en_i,
   input  logic [NUM_LANES-1:0]    lane_en_i,
   input  logic [NUM_LANES-1:0]    cgs_detected_i,
   input  logic [NUM_LANES-1:0]    ilas_done_i,
   input  logic [NUM_LANES-1:0]    lane_err_i,
   input  logic                    resync_req_i,
   output logic                    sync_n_o,
   output logic [NUM_LANES-1:0]    lane_rst_o,
   output logic                    link_up_o,
   output logic [1:0]              state_o,
   output logic [RESYNC_CNT_W-1:0] resync_cnt_o
);
   localparam int HOLD_W = $clog2(SYNC_HOLD_MIN + 1);
   localparam int TMR_W  = $clog2(ILAS_TIMEOUT + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(SYNC_HOLD_MIN);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ILAS_TIMEOUT - 1);

   link_state_e             r_state;
   link_state_e             w_next;
   logic [HOLD_W-1:0]       r_hold_cnt;
   logic [TMR_W-1:0]        r_ilas_tmr;
   logic [RESYNC_CNT_W-1:0] r_resync_cnt;
   logic                    r_sync_n;
   logic                    r_link_up;
   logic [NUM_LANES-1:0]    r_lane_rst;

   logic                    w_link_ok;
   logic                    w_all_cgs;
   logic                    w_all_done;
   logic                    w_beat_err;
   logic                    w_err_clear;
   logic                    w_thresh_hit;
   logic                    w_resync;
   logic                    w_sync_n_nxt;
   logic                    w_link_up_nxt;
   logic [NUM_LANES-1:0]    w_lane_rst_nxt;

   // Disabled lanes are forced to "good" so they never block or trigger anything.
   assign w_link_ok   = link_en_i && (lane_en_i != '0);
   assign w_all_cgs   = &(cgs_detected_i | ~lane_en_i);
   assign w_all_done  = &(ilas_done_i | ~lane_en_i);
   assign w_beat_err  = |(lane_err_i & lane_en_i);
   assign w_err_clear = (r_state != ST_DATA);

   jesd_err_monitor #(
      .ERR_WINDOW (ERR_WINDOW),
      .ERR_THRESH (ERR_THRESH)
   ) u_err_mon (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear      (w_err_clear),
      .beat_err   (w_beat_err),
      .thresh_hit (w_thresh_hit)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_sync_n   <= 1'b1;
         r_lane_rst <= '1;
         r_link_up  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_sync_n   <= w_sync_n_nxt;
         r_lane_rst <= w_lane_rst_nxt;
         r_link_up  <= w_link_up_nxt;
      end
   end

   always_comb begin
      w_next = r_state;
      if (!w_link_ok) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_next = ST_SYNC;
            ST_SYNC: if ((r_hold_cnt == HOLD_MAX) && w_all_cgs) w_next = ST_ILAS;
            ST_ILAS: begin
               if (!w_all_cgs)                 w_next = ST_SYNC;
               else if (w_all_done)            w_next = ST_DATA;
               else if (r_ilas_tmr == TMR_LAST) w_next = ST_SYNC;
            end
            ST_DATA: if (w_thresh_hit || !w_all_cgs || resync_req_i) w_next = ST_SYNC;
            default: w_next = ST_IDLE;
         endcase
      end
   end

   // A resync re-arms every enabled detector for the first SYNC cycle only.
   always_comb begin
      w_resync       = (w_next == ST_SYNC) && ((r_state == ST_ILAS) || (r_state == ST_DATA));
      w_sync_n_nxt   = (w_next != ST_SYNC);
      w_link_up_nxt  = (w_next == ST_DATA);
      w_lane_rst_nxt = ~lane_en_i | ({NUM_LANES{w_resync}} & lane_en_i);
      if (w_next == ST_IDLE) w_lane_rst_nxt = '1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_hold_cnt   <= '0;
         r_ilas_tmr   <= '0;
         r_resync_cnt <= '0;
      end else begin
         if (r_state != ST_SYNC)         r_hold_cnt <= '0;
         else if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);

         if (r_state != ST_ILAS)          r_ilas_tmr <= '0;
         else if (r_ilas_tmr != TMR_LAST) r_ilas_tmr <= r_ilas_tmr + TMR_W'(1);

         if (w_resync && (r_resync_cnt != '1)) r_resync_cnt <= r_resync_cnt + RESYNC_CNT_W'(1);
      end
   end

   assign sync_n_o     = r_sync_n;
   assign lane_rst_o   = r_lane_rst;
   assign link_up_o    = r_link_up;
   assign state_o      = r_state;
   assign resync_cnt_o = r_resync_cnt;

endmodule

// File: tb/tb_jesd_link_ctrl.sv
// tb/tb_jesd_link_ctrl.sv - scoreboard bench for jesd_link_ctrl
// Stimulus queues every expected output-vector change; the monitor pops one per observed change.
module tb_jesd_link_ctrl;

   logic       clk        = 1'b0;
   logic       rst        = 1'b1;
   logic       link_en    = 1'b0;
   logic       resync_req = 1'b0;
   logic [3:0] lane_en    = 4'h0;
   logic [3:0] cgs        = 4'h0;
   logic [3:0] ilas_done  = 4'h0;
   logic [3:0] lane_err   = 4'h0;
   logic       sync_n;
   logic       link_up;
   logic [3:0] lane_rst;
   logic [1:0] state;
   logic [7:0] rc;

   always #5 clk = ~clk;

   jesd_link_ctrl dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .link_en_i      (link_en),
      .lane_en_i      (lane_en),
      .cgs_detected_i (cgs),
      .ilas_done_i    (ilas_done),
      .lane_err_i     (lane_err),
      .resync_req_i   (resync_req),
      .sync_n_o       (sync_n),
      .lane_rst_o     (lane_rst),
      .link_up_o      (link_up),
      .state_o        (state),
      .resync_cnt_o   (rc)
   );

   typedef struct {
      logic [1:0] st;
      logic       sn;
      logic [3:0] lr;
      logic       up;
      logic [7:0] rc;
      int         dwell;
   } exp_t;

   exp_t exp_q[$];
   int   checks     = 0;
   int   errors     = 0;
   logic mask_watch = 1'b0;
   int   mask_bad   = 0;

   task automatic push(input logic [1:0] st, input logic sn, input logic [3:0] lr,
                       input logic up, input logic [7:0] rc_v, input int dwell);
      exp_t e;
      e.st = st; e.sn = sn; e.lr = lr; e.up = up; e.rc = rc_v; e.dwell = dwell;
      exp_q.push_back(e);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while ((state !== st) && (n < budget));
      checks++;
      if (state !== st) begin
         errors++;
         $display("FAIL wait_%s: state=%0d after %0d cycles, required %0d", tag, state, n, st);
      end
   endtask

   task automatic check_reset(input string tag);
      checks++;
      if ({state, sync_n, lane_rst, link_up, rc} !== {2'd0, 1'b1, 4'hF, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL %s: st=%0d sn=%b lr=%h up=%b rc=%0d, required st=0 sn=1 lr=f up=0 rc=0",
                  tag, state, sync_n, lane_rst, link_up, rc);
      end
   endtask

   function automatic bit is_err_beat(input int b);
      return (b < 7) || (b >= 256 && b < 263) || (b >= 511 && b < 519);
   endfunction

   // Monitor: every change of the output vector consumes one expected record.
   initial begin
      logic [15:0] prev_v;
      logic [15:0] cur_v;
      int          dwell_cnt;
      int          idx;
      exp_t        e;
      prev_v    = {2'd0, 1'b1, 4'hF, 1'b0, 8'd0};
      dwell_cnt = 0;
      idx       = 0;
      forever begin
         @(negedge clk);
         if (mask_watch && (lane_rst[3] !== 1'b1)) mask_bad++;
         cur_v = {state, sync_n, lane_rst, link_up, rc};
         if (cur_v !== prev_v) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out%0d: unexpected change to st=%0d sn=%b lr=%h up=%b rc=%0d, required no change",
                        idx, state, sync_n, lane_rst, link_up, rc);
            end else begin
               e = exp_q.pop_front();
               if ((cur_v !== {e.st, e.sn, e.lr, e.up, e.rc}) ||
                   ((e.dwell >= 0) && (e.dwell != dwell_cnt))) begin
                  errors++;
                  $display("FAIL out%0d: got st=%0d sn=%b lr=%h up=%b rc=%0d prev_dwell=%0d, required st=%0d sn=%b lr=%h up=%b rc=%0d prev_dwell=%0d",
                           idx, state, sync_n, lane_rst, link_up, rc, dwell_cnt,
                           e.st, e.sn, e.lr, e.up, e.rc, e.dwell);
               end
            end
            idx++;
            prev_v    = cur_v;
            dwell_cnt = 1;
         end else begin
            dwell_cnt++;
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset("reset_values");

      // Bring-up on all four lanes, CGS arriving in SYNC cycle 3.
      push(2'd1, 1'b0, 4'h0, 1'b0, 8'd0, -1);
      push(2'd2, 1'b1, 4'h0, 1'b0, 8'd0, 17);
      push(2'd3, 1'b1, 4'h0, 1'b1, 8'd0, 4);
      lane_en = 4'hF;
      link_en = 1'b1;
      repeat (3) cycle();
      cgs = 4'hF;
      wait_state(2'd2, 40, "ilas1");
      repeat (3) cycle();
      ilas_done = 4'hF;
      wait_state(2'd3, 4, "data1");

      // Masked lane 3 never locks and its errors are ignored.
      push(2'd0, 1'b1, 4'hF, 1'b0, 8'd0, -1);
      link_en = 1'b0;
      wait_state(2'd0, 4, "idle2");
      mask_watch = 1'b1;
      push(2'd1, 1'b0, 4'h8, 1'b0, 8'd0, -1);
      push(2'd2, 1'b1, 4'h8, 1'b0, 8'd0, 17);
      push(2'd3, 1'b1, 4'h8, 1'b1, 8'd0, 1);
      lane_en   = 4'h7;
      cgs       = 4'h7;
      ilas_done = 4'h0;
      link_en   = 1'b1;
      wait_state(2'd2, 40, "ilas2");
      ilas_done = 4'h7;
      wait_state(2'd3, 4, "data2");
      lane_err = 4'h8;
      repeat (10) cycle();
      lane_err = 4'h0;
      repeat (2) cycle();
      mask_watch = 1'b0;
      checks++;
      if (mask_bad != 0) begin
         errors++;
         $display("FAIL masked_lane_rst: lane_rst[3] low on %0d cycles, required 0", mask_bad);
      end

      // ILAS timeout with ilas_done stuck low.
      push(2'd0, 1'b1, 4'hF, 1'b0, 8'd0, -1);
      link_en = 1'b0;
      wait_state(2'd0, 4, "idle3");
      push(2'd1, 1'b0, 4'h0, 1'b0, 8'd0, -1);
      push(2'd2, 1'b1, 4'h0, 1'b0, 8'd0, 17);
      push(2'd1, 1'b0, 4'hF, 1'b0, 8'd1, 1024);
      push(2'd1, 1'b0, 4'h0, 1'b0, 8'd1, 1);
      push(2'd2, 1'b1, 4'h0, 1'b0, 8'd1, 16);
      push(2'd3, 1'b1, 4'h0, 1'b1, 8'd1, 1);
      lane_en   = 4'hF;
      cgs       = 4'hF;
      ilas_done = 4'h0;
      link_en   = 1'b1;
      wait_state(2'd2, 40, "ilas3");
      wait_state(2'd1, 1100, "ilas_timeout");
      wait_state(2'd2, 40, "ilas4");
      ilas_done = 4'hF;
      wait_state(2'd3, 4, "data3");

      // Error window: 7+wrap, 7+error-on-wrap, then 7 more reach the threshold at beat 518.
      push(2'd1, 1'b0, 4'hF, 1'b0, 8'd2, 519);
      push(2'd1, 1'b0, 4'h0, 1'b0, 8'd2, 1);
      push(2'd2, 1'b1, 4'h0, 1'b0, 8'd2, 16);
      push(2'd3, 1'b1, 4'h0, 1'b1, 8'd2, 1);
      for (int b = 0; b < 519; b++) begin
         lane_err = is_err_beat(b) ? 4'(1 << (b % 4)) : 4'h0;
         cycle();
      end
      lane_err = 4'h0;
      wait_state(2'd3, 40, "data4");

      // Disable and resync request in the same DATA beat.
      push(2'd0, 1'b1, 4'hF, 1'b0, 8'd2, -1);
      resync_req = 1'b1;
      link_en    = 1'b0;
      cycle();
      resync_req = 1'b0;
      cycle();

      // Asynchronous reset in the middle of ILAS.
      push(2'd1, 1'b0, 4'h0, 1'b0, 8'd2, -1);
      push(2'd2, 1'b1, 4'h0, 1'b0, 8'd2, 17);
      push(2'd0, 1'b1, 4'hF, 1'b0, 8'd0, -1);
      ilas_done = 4'h0;
      link_en   = 1'b1;
      wait_state(2'd2, 40, "ilas5");
      repeat (5) cycle();
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset("async_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      link_en = 1'b0;
      cycle();

      // 300 back-to-back resyncs; the counter must stop at 255.
      push(2'd1, 1'b0, 4'h0, 1'b0, 8'd0, -1);
      push(2'd2, 1'b1, 4'h0, 1'b0, 8'd0, 17);
      push(2'd3, 1'b1, 4'h0, 1'b1, 8'd0, 1);
      for (int k = 1; k <= 300; k++) begin
         logic [7:0] n;
         n = (k > 255) ? 8'd255 : 8'(k);
         push(2'd1, 1'b0, 4'hF, 1'b0, n, 1);
         push(2'd1, 1'b0, 4'h0, 1'b0, n, 1);
         push(2'd2, 1'b1, 4'h0, 1'b0, n, 16);
         push(2'd3, 1'b1, 4'h0, 1'b1, n, 1);
      end
      push(2'd0, 1'b1, 4'hF, 1'b0, 8'd255, 1);
      lane_en    = 4'hF;
      cgs        = 4'hF;
      ilas_done  = 4'hF;
      resync_req = 1'b1;
      link_en    = 1'b1;
      begin
         int n_wait;
         n_wait = 0;
         while ((exp_q.size() > 1) && (n_wait < 7000)) begin
            @(negedge clk);
            #1;
            n_wait++;
         end
      end
      link_en = 1'b0;
      repeat (3) cycle();
      resync_req = 1'b0;
      repeat (3) cycle();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected changes never seen, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
